// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronizes the serial pin, walks START/DATA/STOP/CLEANUP,
// assembles the byte LSB first and emits one-cycle data-valid or framing-error strobes.
module uart_rx_controller #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Rx_Serial,
   output logic        o_Rx_DV,
   output logic [7:0]  o_Rx_Byte,
   output logic        o_Frame_Err,
   output logic        o_Busy,
   output logic [2:0]  o_SM_Main,
   output logic [2:0]  o_Bit_Index,
   output logic [15:0] o_Clock_Count
);

   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_START   = 3'b001;
   localparam logic [2:0] S_DATA    = 3'b010;
   localparam logic [2:0] S_STOP    = 3'b011;
   localparam logic [2:0] S_CLEANUP = 3'b100;

   localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

   logic        r_Rx_Meta;
   logic        r_Rx_Sync;
   logic [2:0]  r_SM_Main;
   logic [2:0]  w_SM_Next;
   logic [15:0] r_Clock_Count;
   logic [2:0]  r_Bit_Index;
   logic [7:0]  r_Shift;
   logic [7:0]  r_Rx_Byte;
   logic        r_Rx_DV;
   logic        r_Frame_Err;
   logic        w_Half_Hit;
   logic        w_Full_Hit;
   logic        w_Stop_Good;
   logic        w_Stop_Bad;
   logic        w_Busy;

   // Two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_Rx_Meta <= 1'b1;
         r_Rx_Sync <= 1'b1;
      end else begin
         r_Rx_Meta <= i_Rx_Serial;
         r_Rx_Sync <= r_Rx_Meta;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) r_SM_Main <= S_IDLE;
      else         r_SM_Main <= w_SM_Next;
   end

   always_comb begin
      w_SM_Next = S_IDLE;
      case (r_SM_Main)
         S_IDLE:    w_SM_Next = r_Rx_Sync ? S_IDLE : S_START;
         S_START: begin
            if (!w_Half_Hit)    w_SM_Next = S_START;
            else if (r_Rx_Sync) w_SM_Next = S_IDLE;
            else                w_SM_Next = S_DATA;
         end
         S_DATA:    w_SM_Next = (w_Full_Hit && r_Bit_Index == 3'd7) ? S_STOP : S_DATA;
         S_STOP:    w_SM_Next = w_Full_Hit ? S_CLEANUP : S_STOP;
         // Holding here while the line is low keeps a break from retriggering a frame
         S_CLEANUP: w_SM_Next = r_Rx_Sync ? S_IDLE : S_CLEANUP;
         default:   w_SM_Next = S_IDLE;
      endcase
   end

   always_comb begin
      w_Half_Hit  = (r_Clock_Count == HALF);
      w_Full_Hit  = (r_Clock_Count == FULL);
      w_Stop_Good = (r_SM_Main == S_STOP) && w_Full_Hit && r_Rx_Sync;
      w_Stop_Bad  = (r_SM_Main == S_STOP) && w_Full_Hit && !r_Rx_Sync;
      w_Busy      = (r_SM_Main != S_IDLE);
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_Clock_Count <= 16'd0;
         r_Bit_Index   <= 3'd0;
         r_Shift       <= 8'h00;
         r_Rx_Byte     <= 8'h00;
         r_Rx_DV       <= 1'b0;
         r_Frame_Err   <= 1'b0;
      end else begin
         r_Rx_DV     <= w_Stop_Good;
         r_Frame_Err <= w_Stop_Bad;
         if (w_Stop_Good) r_Rx_Byte <= r_Shift;
         case (r_SM_Main)
            S_START: begin
               r_Bit_Index <= 3'd0;
               if (r_Clock_Count < HALF) r_Clock_Count <= r_Clock_Count + 16'd1;
               else                      r_Clock_Count <= 16'd0;
            end
            S_DATA: begin
               if (r_Clock_Count < FULL) begin
                  r_Clock_Count <= r_Clock_Count + 16'd1;
               end else begin
                  r_Clock_Count          <= 16'd0;
                  r_Shift[r_Bit_Index]   <= r_Rx_Sync;
                  r_Bit_Index            <= (r_Bit_Index == 3'd7) ? 3'd0 : r_Bit_Index + 3'd1;
               end
            end
            S_STOP: begin
               if (r_Clock_Count < FULL) r_Clock_Count <= r_Clock_Count + 16'd1;
               else                      r_Clock_Count <= 16'd0;
            end
            default: begin
               r_Clock_Count <= 16'd0;
               r_Bit_Index   <= 3'd0;
            end
         endcase
      end
   end

   assign o_Rx_DV       = r_Rx_DV;
   assign o_Rx_Byte     = r_Rx_Byte;
   assign o_Frame_Err   = r_Frame_Err;
   assign o_Busy        = w_Busy;
   assign o_SM_Main     = r_SM_Main;
   assign o_Bit_Index   = r_Bit_Index;
   assign o_Clock_Count = r_Clock_Count;

endmodule
